// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Executes mult/multu/div/divu over WIDTH+1 cycles; mthi/mtlo write in one edge.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               isdiv_q, isdiv_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dvz_q, dvz_d;
    // mult: {hi,lo} accumulator; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // mult: multiplicand shifted left each step; div: divisor in low half
    logic [2*WIDTH-1:0] opa_q, opa_d;
    // mult: multiplier shifted right each step
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_md;
    logic               is_div;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shrem;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign is_md  = (funct == F_MULT) || (funct == F_MULTU) ||
                    (funct == F_DIV)  || (funct == F_DIVU);
    assign is_div = (funct == F_DIV) || (funct == F_DIVU);
    assign sgn    = (funct == F_MULT) || (funct == F_DIV);
    assign abs_a  = (sgn && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign abs_b  = (sgn && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // restoring divide: partial remainder shifted left with next dividend bit
    assign shrem = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff  = shrem - {1'b0, opa_q[WIDTH-1:0]};
    assign quo   = acc_q[WIDTH-1:0];
    assign rem   = acc_q[2*WIDTH-1:WIDTH];

    // state and working registers, all cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            isdiv_q <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dvz_q   <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isdiv_q <= isdiv_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dvz_q   <= dvz_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // next-state, iteration step and result fix-up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        isdiv_d = isdiv_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dvz_d   = dvz_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_md) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        isdiv_d = is_div;
                        negq_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_d  = sgn & a[WIDTH-1];
                        dvz_d   = (b == '0);
                        acc_d   = is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
                        opa_d   = is_div ? {{WIDTH{1'b0}}, abs_b}
                                         : {{WIDTH{1'b0}}, abs_a};
                        opb_d   = abs_b;
                    end else if (funct == F_MTHI) begin
                        hi_d = a;
                    end else if (funct == F_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (isdiv_q) begin
                    if (!diff[WIDTH]) begin
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end
                    opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (isdiv_q) begin
                    lo_d = dvz_q  ? {WIDTH{1'b1}}
                         : negq_q ? ({WIDTH{1'b0}} - quo) : quo;
                    hi_d = negr_q ? ({WIDTH{1'b0}} - rem) : rem;
                end else begin
                    {hi_d, lo_d} = negq_q ? ({(2*WIDTH){1'b0}} - acc_q)
                                          : acc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: vector table with a result scoreboard,
// plus sequences for move-to, ignore-while-busy, reset abort and WIDTH=8.
module tb_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [5:0]  funct8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int          nvec;
    int          nfail;
    logic [63:0] sbq[$];
    logic [63:0] mon_e;
    vec_t        tbl[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .funct (funct8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .hi    (hi8),
        .lo    (lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f,
                                  input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] h,
                                  output logic [31:0] l);
        logic [63:0] p;
        longint sx;
        longint sy;
        h  = '0;
        l  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (f)
            F_MULT: begin
                p = 64'(sx * sy);
                h = p[63:32];
                l = p[31:0];
            end
            F_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                h = p[63:32];
                l = p[31:0];
            end
            F_DIV: begin
                if (y == 0) begin
                    h = x;
                    l = '1;
                end else begin
                    l = 32'(sx / sy);
                    h = 32'(sx % sy);
                end
            end
            F_DIVU: begin
                if (y == 0) begin
                    h = x;
                    l = '1;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    // scoreboard: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL spurious_done: got done=1 expected no pending op");
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_hi", hi, mon_e[63:32]);
                chk("sb_lo", lo, mon_e[31:0]);
            end
        end
    end

    function automatic bit is_md(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) ||
               (f == F_DIV)  || (f == F_DIVU);
    endfunction

    // drive one request now; returns 1 time unit after the result edge
    task automatic do_op(input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh,
                         input logic [31:0] el);
        int n;
        funct = f;
        a     = x;
        b     = y;
        start = 1'b1;
        if (is_md(f)) sbq.push_back({eh, el});
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (is_md(f)) begin
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("busy_cycles", n, 33);
            chk("done_pulse", {31'b0, done}, 1);
        end else begin
            chk("move_busy", {31'b0, busy}, 0);
            chk("move_hi", hi, eh);
            chk("move_lo", lo, el);
        end
    endtask

    task automatic do8(input logic [5:0] f, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] eh,
                       input logic [7:0] el);
        int k;
        @(negedge clk);
        funct8 = f;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("w8_busy", {31'b0, busy8}, 1);
        k = 0;
        while (!done8 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("w8_latency", k, 9);
        chk("w8_hi", {24'b0, hi8}, {24'b0, eh});
        chk("w8_lo", {24'b0, lo8}, {24'b0, el});
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] lo_before;
        bit          seen;
        logic [5:0]  ops[4];

        nvec   = 0;
        nfail  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        funct  = '0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        funct8 = '0;
        a8     = '0;
        b8     = '0;
        ops[0] = F_MULT;
        ops[1] = F_MULTU;
        ops[2] = F_DIV;
        ops[3] = F_DIVU;

        tbl.push_back('{F_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB});
        tbl.push_back('{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        tbl.push_back('{F_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back('{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});
        tbl.push_back('{F_DIVU,  32'd100,      32'h0,        32'h00000064, 32'hFFFFFFFF});
        tbl.push_back('{F_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF});
        tbl.push_back('{F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF});
        tbl.push_back('{F_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        tbl.push_back('{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
        tbl.push_back('{F_MULT,  32'h80000000, 32'h1,        32'hFFFFFFFF, 32'h80000000});
        tbl.push_back('{F_MULTU, 32'h0,        32'h12345,    32'h0,        32'h0});
        for (int i = 0; i < 16; i++) begin
            f = ops[i % 4];
            x = $urandom;
            y = $urandom;
            if (i >= 8) y = 32'($urandom_range(1, 300));
            if (i >= 12 && f == F_DIV) y = 32'd0 - y;
            model(f, x, y, eh, el);
            tbl.push_back('{f, x, y, eh, el});
        end

        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_hi8", {24'b0, hi8}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);
        end

        @(negedge clk);
        do_op(F_MTHI, 32'h12345678, 32'h0, 32'h12345678,
              tbl[tbl.size()-1].elo);
        @(negedge clk);
        do_op(F_MTLO, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        do_op(6'h20, 32'hFFFFFFFF, 32'h1, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        do_op(6'b010000, 32'h5, 32'h5, 32'h12345678, 32'h9ABCDEF0);

        @(negedge clk);
        lo_before = 32'h9ABCDEF0;
        funct = F_MULTU;
        a     = 32'h00010000;
        b     = 32'h00000030;
        start = 1'b1;
        sbq.push_back({32'h0, 32'h00300000});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        funct = F_MTLO;
        a     = 32'hAAAAAAAA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_ignored", lo, lo_before);
        chk("busy_kept", {31'b0, busy}, 1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("ignore_done_seen", {31'b0, seen}, 1);

        @(negedge clk);
        do_op(F_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);
        do_op(F_MULT, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4);

        @(negedge clk);
        do_op(F_MTHI, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'hFFFFFFF4);
        @(negedge clk);
        funct = F_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'b0, seen}, 0);
        @(negedge clk);
        do_op(F_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);

        do8(F_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        do8(F_DIVU, 8'd200, 8'd7, 8'h04, 8'h1C);
        do8(F_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
        do8(F_MULT, 8'hFD, 8'h07, 8'hFF, 8'hEB);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
